// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and data memory.
// Stores are queued and drained over a valid/ready port. Loads are forwarded
// from the youngest matching pending store, otherwise memory data passes through.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_wvalid,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_wready,
  output logic [31:0]      mem_raddr,
  input  logic [31:0]      mem_rdata,
  output logic             buf_empty,
  output logic [CNT_W-1:0] buf_count
);

  localparam int unsigned WADDR_W = 30;
  localparam int unsigned DATA_W  = 32;

  logic [WADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;
  logic [PTR_W-1:0]   fwd_idx;

  // Occupancy flags and handshake qualifiers
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == CNT_W'(0));
    push  = cpu_we & ~full;
    pop   = ~empty & mem_wready;
  end

  // Entry storage; contents are don't-care once the slot is outside rd..wr
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= cpu_addr[31:2];
      data_q[wr_ptr] <= cpu_wdata;
    end
  end

  // Pointers and occupancy; reset discards all pending stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Forwarding search oldest-to-youngest so the youngest hit wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[fwd_idx] == cpu_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Core-facing and memory-facing outputs
  always_comb begin
    cpu_stall  = cpu_we & full;
    cpu_rdata  = fwd_hit ? fwd_data : mem_rdata;
    mem_raddr  = cpu_addr;
    mem_wvalid = ~empty;
    mem_waddr  = {addr_q[rd_ptr], 2'b00};
    mem_wdata  = data_q[rd_ptr];
    buf_empty  = empty;
    buf_count  = count;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, forwarding, ordering, full stall,
// back-to-back streaming and reset mid-drain.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wready;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        buf_empty;
  logic [2:0]  buf_count;

  int total;
  int bad;

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  store_buffer #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .buf_empty  (buf_empty),
    .buf_count  (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: record every accepted write
  always @(posedge clk) begin
    if (reset && mem_wvalid && mem_wready) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_wready = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    total++; if (mem_wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid got=%0h want=0", mem_wvalid); end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h want=1", buf_empty); end
    total++; if (buf_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", buf_count); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", cpu_stall); end
  endtask

  task automatic test_single();
    clear_log();
    mem_wready = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h54;
    tick();
    cpu_we = 1'b0;
    total++; if (mem_wvalid !== 1'b1) begin bad++; $display("FAIL single_wvalid got=%0h want=1", mem_wvalid); end
    total++; if (mem_waddr !== 32'h10) begin bad++; $display("FAIL single_waddr got=%0h want=10", mem_waddr); end
    total++; if (mem_wdata !== 32'h54) begin bad++; $display("FAIL single_wdata got=%0h want=54", mem_wdata); end
    total++; if (buf_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", buf_count); end
    mem_rdata = 32'hDEADBEEF;
    cpu_addr = 32'h10; #1;
    total++; if (cpu_rdata !== 32'h54) begin bad++; $display("FAIL fwd_hit got=%0h want=54", cpu_rdata); end
    total++; if (mem_raddr !== 32'h10) begin bad++; $display("FAIL raddr got=%0h want=10", mem_raddr); end
    cpu_addr = 32'h14; #1;
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fwd_miss got=%0h want=deadbeef", cpu_rdata); end
    cpu_addr = 32'h13; #1;
    total++; if (cpu_rdata !== 32'h54) begin bad++; $display("FAIL fwd_lowbits got=%0h want=54", cpu_rdata); end
    cpu_addr = 32'h10; mem_wready = 1'b1; #1;
    total++; if (cpu_rdata !== 32'h54) begin bad++; $display("FAIL fwd_popping got=%0h want=54", cpu_rdata); end
    tick();
    mem_wready = 1'b0; #1;
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL single_drained got=%0h want=1", buf_empty); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fwd_after_drain got=%0h want=deadbeef", cpu_rdata); end
    total++; if (log_addr.size() != 1) begin bad++; $display("FAIL single_log_size got=%0d want=1", log_addr.size()); end
    else if (log_addr[0] !== 32'h10 || log_data[0] !== 32'h54) begin
      bad++; $display("FAIL single_log got=%0h/%0h want=10/54", log_addr[0], log_data[0]);
    end
  endtask

  task automatic test_same_addr();
    clear_log();
    mem_wready = 1'b0; mem_rdata = 32'h0BAD0BAD;
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1; #1;
    total++; if (cpu_rdata !== 32'h0BAD0BAD) begin bad++; $display("FAIL push_invisible got=%0h want=0bad0bad", cpu_rdata); end
    tick();
    cpu_wdata = 32'h2; #1;
    total++; if (cpu_rdata !== 32'h1) begin bad++; $display("FAIL fwd_older got=%0h want=1", cpu_rdata); end
    tick();
    cpu_we = 1'b0; #1;
    total++; if (cpu_rdata !== 32'h2) begin bad++; $display("FAIL fwd_youngest got=%0h want=2", cpu_rdata); end
    mem_wready = 1'b1;
    tick(); tick();
    mem_wready = 1'b0;
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL same_empty got=%0h want=1", buf_empty); end
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL same_log_size got=%0d want=2", log_addr.size()); end
    else if (log_addr[0] !== 32'h20 || log_data[0] !== 32'h1 || log_addr[1] !== 32'h20 || log_data[1] !== 32'h2) begin
      bad++; $display("FAIL same_order got=%0h/%0h,%0h/%0h want=20/1,20/2", log_addr[0], log_data[0], log_addr[1], log_data[1]);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_a [5];
    clear_log();
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC; exp_a[4] = 32'h30;
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_addr = exp_a[i]; cpu_wdata = exp_a[i] + 32'h100;
      tick();
    end
    cpu_addr = 32'h30; cpu_wdata = 32'h130; #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%0h want=1", cpu_stall); end
    total++; if (buf_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", buf_count); end
    tick();
    total++; if (buf_count !== 3'd4) begin bad++; $display("FAIL full_held got=%0d want=4", buf_count); end
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0; #1;
    total++; if (buf_count !== 3'd3) begin bad++; $display("FAIL full_pop_noenq got=%0d want=3", buf_count); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL full_unstall got=%0h want=0", cpu_stall); end
    tick();
    cpu_we = 1'b0;
    total++; if (buf_count !== 3'd4) begin bad++; $display("FAIL full_accept got=%0d want=4", buf_count); end
    mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_wready = 1'b0;
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%0h want=1", buf_empty); end
    total++; if (log_addr.size() != 5) begin bad++; $display("FAIL full_log_size got=%0d want=5", log_addr.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_a[i] + 32'h100) begin
          bad++; $display("FAIL full_order[%0d] got=%0h/%0h want=%0h/%0h", i, log_addr[i], log_data[i], exp_a[i], exp_a[i] + 32'h100);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    mem_wready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h100 + 32'(4 * i); cpu_wdata = 32'hA0 + 32'(i); #1;
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall[%0d] got=%0h want=0", i, cpu_stall); end
      tick();
      total++; if (buf_count !== 3'd1) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=1", i, buf_count); end
    end
    cpu_we = 1'b0;
    tick();
    mem_wready = 1'b0;
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0h want=1", buf_empty); end
    total++; if (log_addr.size() != 10) begin bad++; $display("FAIL b2b_log_size got=%0d want=10", log_addr.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        if (log_addr[i] !== 32'h100 + 32'(4 * i) || log_data[i] !== 32'hA0 + 32'(i)) begin
          bad++; $display("FAIL b2b_order[%0d] got=%0h/%0h want=%0h/%0h", i, log_addr[i], log_data[i], 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h200 + 32'(4 * i); cpu_wdata = 32'h70 + 32'(i);
      tick();
    end
    cpu_we = 1'b0;
    total++; if (buf_count !== 3'd3) begin bad++; $display("FAIL mid_count got=%0d want=3", buf_count); end
    mem_wready = 1'b1;
    #2 reset = 1'b0;
    #1;
    total++; if (mem_wvalid !== 1'b0) begin bad++; $display("FAIL mid_wvalid got=%0h want=0", mem_wvalid); end
    total++; if (buf_count !== 3'd0) begin bad++; $display("FAIL mid_rcount got=%0d want=0", buf_count); end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%0h want=1", buf_empty); end
    tick();
    reset = 1'b1;
    clear_log();
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h99;
    tick();
    cpu_we = 1'b0;
    tick(); tick();
    mem_wready = 1'b0;
    total++; if (log_addr.size() != 1) begin bad++; $display("FAIL mid_log_size got=%0d want=1", log_addr.size()); end
    else if (log_addr[0] !== 32'h40 || log_data[0] !== 32'h99) begin
      bad++; $display("FAIL mid_log got=%0h/%0h want=40/99", log_addr[0], log_data[0]);
    end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL mid_final_empty got=%0h want=1", buf_empty); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_same_addr();
    test_full();
    test_back_to_back();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
